// File: rtl/mul_pkg.sv
// Shared types and size helpers for the nibble-bus sequential multiplier.
// Sizes derive from the operand width so every user agrees on bus widths.
package mul_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } mul_state_e;

    function automatic int f_nop(input int w);
        return w / NIB_W;
    endfunction

    function automatic int f_nres(input int w);
        return (2 * w) / NIB_W;
    endfunction

    // Select fields are at least one bit wide even when there is a single nibble.
    function automatic int f_nsw(input int w);
        return ($clog2(f_nop(w)) < 1) ? 1 : $clog2(f_nop(w));
    endfunction

    function automatic int f_rsw(input int w);
        return ($clog2(f_nres(w)) < 1) ? 1 : $clog2(f_nres(w));
    endfunction

    function automatic int f_cw(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_multiply_core.sv
// Shift-and-add datapath: magnitudes in, one partial product per step,
// sign restored combinationally on the way out.
module seq_multiply_core
    import mul_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CW    = f_cw(WIDTH),
    localparam int PW    = 2 * WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_init,
    input  logic             i_step,
    input  logic             i_finish,
    input  logic             i_neg,
    input  logic [WIDTH-1:0] i_mplier,
    input  logic [WIDTH-1:0] i_mcand,
    output logic [PW-1:0]    o_product,
    output logic             o_last
);

    logic [PW-1:0]    r_acc;
    logic [PW-1:0]    r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [CW-1:0]    r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else if (i_init) begin
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, i_mcand};
            r_mplier <= i_mplier;
            r_cnt    <= CW'(WIDTH);
        end else if (i_step) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - CW'(1);
        end else if (i_finish) begin
            // acc is kept so the product stays valid during the FIX cycle
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end
    end

    assign o_last    = (r_cnt == CW'(1));
    assign o_product = i_neg ? (~r_acc + PW'(1)) : r_acc;

endmodule

// File: rtl/seq_multiply_n.sv
// Nibble-bus sequential multiplier: operand registers, START/BUSY/DONE
// control FSM, result register and the nibble read mux.
module seq_multiply_n
    import mul_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int NOP   = f_nop(WIDTH),
    localparam int NRES  = f_nres(WIDTH),
    localparam int NSW   = f_nsw(WIDTH),
    localparam int RSW   = f_rsw(WIDTH),
    localparam int PW    = 2 * WIDTH
) (
    input  logic           MUL_CLK,
    input  logic           RST_N,
    input  logic [3:0]     DIN,
    input  logic           LOAD,
    input  logic           OPSEL,
    input  logic [NSW-1:0] NSEL,
    input  logic           START,
    input  logic           SIGNED,
    input  logic [RSW-1:0] RSEL,
    output logic [3:0]     R,
    output logic           BUSY,
    output logic           DONE
);

    mul_state_e       r_state;
    mul_state_e       w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_sgn;
    logic             r_xs;
    logic [PW-1:0]    r_res;
    logic             r_busy;
    logic             r_done;

    logic             w_init;
    logic             w_step;
    logic             w_finish;
    logic             w_last;
    logic             w_neg;
    logic [WIDTH-1:0] w_mplier;
    logic [WIDTH-1:0] w_mcand;
    logic [PW-1:0]    w_product;

    // The most negative operand negates to itself, which reads correctly as unsigned.
    assign w_mplier = (SIGNED && r_a[WIDTH-1]) ? (~r_a + WIDTH'(1)) : r_a;
    assign w_mcand  = (SIGNED && r_b[WIDTH-1]) ? (~r_b + WIDTH'(1)) : r_b;
    assign w_neg    = r_sgn & r_xs;

    always_comb begin
        w_next   = r_state;
        w_init   = 1'b0;
        w_step   = 1'b0;
        w_finish = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (START) begin
                    w_init = 1'b1;
                    w_next = CALC;
                end
            end
            CALC: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_next = FIX;
                end
            end
            FIX: begin
                w_finish = 1'b1;
                w_next   = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge MUL_CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sgn   <= 1'b0;
            r_xs    <= 1'b0;
            r_res   <= '0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != IDLE);
            r_done  <= (r_state == FIX);
            if (w_init) begin
                r_sgn <= SIGNED;
                r_xs  <= r_a[WIDTH-1] ^ r_b[WIDTH-1];
            end
            if (r_state == FIX) begin
                r_res <= w_product;
            end
        end
    end

    // Writes land after START has already sampled the old operand values.
    always_ff @(posedge MUL_CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_a <= '0;
            r_b <= '0;
        end else if (r_state == IDLE && LOAD) begin
            for (int i = 0; i < NOP; i++) begin
                if (NSEL == NSW'(i)) begin
                    if (OPSEL) begin
                        r_b[NIB_W*i +: NIB_W] <= DIN;
                    end else begin
                        r_a[NIB_W*i +: NIB_W] <= DIN;
                    end
                end
            end
        end
    end

    always_comb begin
        R = '0;
        for (int i = 0; i < NRES; i++) begin
            if (RSEL == RSW'(i)) begin
                R = r_res[NIB_W*i +: NIB_W];
            end
        end
    end

    assign BUSY = r_busy;
    assign DONE = r_done;

    seq_multiply_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk       (MUL_CLK),
        .rst_n     (RST_N),
        .i_init    (w_init),
        .i_step    (w_step),
        .i_finish  (w_finish),
        .i_neg     (w_neg),
        .i_mplier  (w_mplier),
        .i_mcand   (w_mcand),
        .o_product (w_product),
        .o_last    (w_last)
    );

endmodule

// File: doc/seq_multiply_n.md
Name: seq_multiply_n

Overview:
Parametrised sequential shift-and-add multiplier. Operands of WIDTH bits are loaded a nibble at a time over a 4-bit bus. Supports unsigned and signed (two's complement) modes, with a START/BUSY/DONE handshake. The 2*WIDTH-bit product is held in a result register and read back a nibble at a time. It is the generalised successor of the fixed 4x4 nibble multiplier and sits on the same nibble-wide peripheral bus.

Parameters:
WIDTH, 8, operand width in bits; multiple of 4, >= 4
(derived localparams, not overridable: NOP = WIDTH/4 operand nibbles; NRES = WIDTH/2 result nibbles; NSW = max(1, clog2(NOP)); RSW = max(1, clog2(NRES)); CW = clog2(WIDTH+1))

Ports:
MUL_CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
DIN  in  4  operand nibble write data
LOAD  in  1  write DIN into the operand nibble selected by OPSEL/NSEL
OPSEL  in  1  0 = operand A (multiplier), 1 = operand B (multiplicand)
NSEL  in  NSW  operand nibble index, 0 = least significant
START  in  1  begin multiplication (sampled when idle)
SIGNED  in  1  mode, sampled with START: 1 = two's complement, 0 = unsigned
RSEL  in  RSW  result nibble index, 0 = least significant
R  out  4  result nibble RES[4*RSEL+3 : 4*RSEL], combinational from the result register
BUSY  out  1  high while a multiplication is in progress
DONE  out  1  one-cycle pulse when RES has been updated

Behaviour:
- Reset (RST_N low, asynchronous): state IDLE; A, B, RES, accumulator and counter all 0; BUSY = 0; DONE = 0; R = 0.
- States: IDLE, CALC, FIX.
- IDLE:
  - LOAD writes DIN into nibble NSEL of A or B. An NSEL >= NOP is ignored.
  - START at edge e0 does the following:
    - latches SIGNED into sgn_q.
    - mplier = |A|, mcand = |B| (absolute values only if SIGNED, else raw), zero-extended to 2*WIDTH.
    - neg_q = SIGNED & (A[W-1] ^ B[W-1]).
    - acc = 0; cnt = WIDTH; go to CALC.
- LOAD and START on the same IDLE edge: START uses the operand values from before the write. The write still takes effect.
- CALC, each edge:
  - if mplier[0], acc += mcand.
  - mcand <<= 1; mplier >>= 1; cnt -= 1.
  - the edge that takes cnt to 0 moves to FIX. CALC therefore lasts exactly WIDTH edges (e1..eW).
- FIX, edge eW+1:
  - RES = neg_q ? (~acc + 1) : acc, modulo 2^(2*WIDTH).
  - DONE = 1 for the following cycle only; state goes to IDLE.
- BUSY = (state != IDLE), registered. It is high in the WIDTH+1 cycles after e0.
- DONE is high in the cycle after eW+1 and coincides with BUSY = 0. START may be accepted on that same cycle.
- Latency: RES is valid in the cycle after eW+1, i.e. WIDTH+2 edges counting e0.
- Width rules:
  - The magnitude of the most negative operand (2^(W-1)) fits in W unsigned bits.
  - The product always fits in 2*WIDTH bits in both modes, so no overflow flag is needed.
- While BUSY, START and LOAD are ignored: operands and sgn_q do not change.
- RES changes only in FIX. During a computation R keeps returning the previous result.
- RSEL >= NRES (non-power-of-two WIDTH): R = 0.
- Reset mid-operation aborts the computation. All state returns to reset values, with no DONE pulse.

Decomposition:
- Package mul_pkg:
  - state enum (IDLE, CALC, FIX).
  - nibble width constant (4).
  - functions for NOP/NRES/NSW/RSW.
- One sub-module, seq_multiply_core. It holds acc, mcand, mplier and cnt, with inputs init/step/finish. It produces the final product and a last-step flag.
- The top level holds the operand nibble registers, the FSM, the handshake, RES and the R mux.

Test Plan:
1. Unsigned, WIDTH=8: A=0xB7, B=0x5C, START -> BUSY for 9 cycles, DONE pulse 1 cycle, RES=0x41C4; RSEL 0..3 reads 4,C,1,4.
2. Signed, WIDTH=8:
   - A=0x80, B=0x80 -> 0x4000.
   - A=0xFF, B=0x01 -> 0xFFFF.
   - A=0xFD, B=0x05 -> 0xFFF1.
   - Same A=0xFD, B=0x05 with SIGNED=0 -> 0x04F1.
3. LOAD A nibble and pulse START during BUSY -> both ignored: result equals the product of the original operands, A readback unchanged, exactly one DONE.
4. Prior RES=0x41C4, start 0x02*0x03 -> R shows 0x41C4 nibbles until DONE, then 0x0006. A back-to-back START on the DONE cycle is accepted.
5. Assert RST_N low at CALC step 4 -> BUSY, DONE, R go to 0 immediately. After release, START with no loads -> RES=0x0000.
6. WIDTH=12 instance: A=B=0xFFF unsigned -> RES=0xFFE001, DONE after 14 edges. RSEL=6 and 7 read 0. NSEL=3 LOAD is ignored.
